// File: rtl/hazard_unit.sv
// Load-use hazard detection with a shadow EX/MEM/WB copy of destination-register info.
// Optional HAZARD_PERF_EN adds a saturating 16-bit stall cycle counter (stall_count).
module hazard_unit #(
  parameter int unsigned REGW = 5
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            pipe_en,
  input  logic            flush,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_regwr,
  input  logic [REGW-1:0] id_wsel,
  input  logic            id_memread,
  input  logic            id_lui,
  output logic            stall,
  output logic            mem_regwr,
  output logic [REGW-1:0] mem_wsel,
  output logic            mem_lui,
  output logic            wb_regwr,
  output logic [REGW-1:0] wb_wsel
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]     stall_count
`endif
);

  logic            ex_regwr_q, ex_memread_q, ex_lui_q;
  logic [REGW-1:0] ex_wsel_q;
  logic            mem_regwr_q, mem_lui_q;
  logic [REGW-1:0] mem_wsel_q;
  logic            wb_regwr_q;
  logic [REGW-1:0] wb_wsel_q;

  logic            ins_regwr, ins_memread, ins_lui;
  logic [REGW-1:0] ins_wsel;

  // Insert rule keeps EX wsel nonzero whenever regwr is set, so no $0 check here.
  assign stall = ex_regwr_q & ex_memread_q & ((ex_wsel_q == id_rs) | (ex_wsel_q == id_rt));

  always_comb begin
    ins_regwr   = id_regwr & (id_wsel != '0);
    ins_wsel    = id_wsel;
    ins_memread = id_memread;
    ins_lui     = id_lui;
    if (flush || stall) begin
      ins_regwr   = 1'b0;
      ins_wsel    = '0;
      ins_memread = 1'b0;
      ins_lui     = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ex_regwr_q   <= 1'b0;
      ex_wsel_q    <= '0;
      ex_memread_q <= 1'b0;
      ex_lui_q     <= 1'b0;
      mem_regwr_q  <= 1'b0;
      mem_wsel_q   <= '0;
      mem_lui_q    <= 1'b0;
      wb_regwr_q   <= 1'b0;
      wb_wsel_q    <= '0;
    end else if (pipe_en) begin
      wb_regwr_q   <= mem_regwr_q;
      wb_wsel_q    <= mem_wsel_q;
      mem_regwr_q  <= ex_regwr_q;
      mem_wsel_q   <= ex_wsel_q;
      mem_lui_q    <= ex_lui_q;
      ex_regwr_q   <= ins_regwr;
      ex_wsel_q    <= ins_wsel;
      ex_memread_q <= ins_memread;
      ex_lui_q     <= ins_lui;
    end
  end

  assign mem_regwr = mem_regwr_q;
  assign mem_wsel  = mem_wsel_q;
  assign mem_lui   = mem_lui_q;
  assign wb_regwr  = wb_regwr_q;
  assign wb_wsel   = wb_wsel_q;

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_count_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_count_q <= '0;
    end else if (stall && pipe_en && (stall_count_q != 16'hFFFF)) begin
      stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus random traffic vs. a queue model.
module tb_hazard_unit;

  logic       CLK, nRST, pipe_en, flush;
  logic [4:0] id_rs, id_rt, id_wsel;
  logic       id_regwr, id_memread, id_lui;
  logic       stall, mem_regwr, mem_lui, wb_regwr;
  logic [4:0] mem_wsel, wb_wsel;
  logic [15:0] stall_count;

  hazard_unit #(.REGW(5)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .pipe_en    (pipe_en),
    .flush      (flush),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_regwr   (id_regwr),
    .id_wsel    (id_wsel),
    .id_memread (id_memread),
    .id_lui     (id_lui),
    .stall      (stall),
    .mem_regwr  (mem_regwr),
    .mem_wsel   (mem_wsel),
    .mem_lui    (mem_lui),
    .wb_regwr   (wb_regwr),
    .wb_wsel    (wb_wsel)
`ifdef HAZARD_PERF_EN
    ,
    .stall_count(stall_count)
`endif
  );

`ifndef HAZARD_PERF_EN
  assign stall_count = 16'd0;
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       regwr;
    logic [4:0] wsel;
    logic       memread;
    logic       lui;
  } slot_t;

  // Model pipeline: index 0 = EX, 1 = MEM, 2 = WB.
  slot_t slots[$];
  int    model_cnt;
  int    n_cmp, n_err;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    slots.delete();
    for (int i = 0; i < 3; i++) slots.push_back('0);
    model_cnt = 0;
  endtask

  function automatic logic model_stall();
    slot_t ex;
    ex = slots[0];
    return ex.regwr && ex.memread && (ex.wsel == id_rs || ex.wsel == id_rt);
  endfunction

  task automatic apply(input logic en, input logic fl, input logic rw, input logic mr,
                       input logic lu, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] ws);
    pipe_en = en; flush = fl; id_regwr = rw; id_memread = mr; id_lui = lu;
    id_rs = rs; id_rt = rt; id_wsel = ws;
  endtask

  task automatic check_outputs();
    slot_t m, w;
    m = slots[1];
    w = slots[2];
    check("stall", int'(stall), int'(model_stall()));
    check("mem_regwr", int'(mem_regwr), int'(m.regwr));
    check("mem_wsel", int'(mem_wsel), int'(m.wsel));
    check("mem_lui", int'(mem_lui), int'(m.lui));
    check("wb_regwr", int'(wb_regwr), int'(w.regwr));
    check("wb_wsel", int'(wb_wsel), int'(w.wsel));
`ifdef HAZARD_PERF_EN
    check("stall_count", int'(stall_count), model_cnt);
`endif
  endtask

  // Check current cycle, then take one clock edge and advance the model.
  task automatic step();
    logic  s;
    slot_t ins;
    #1;
    check_outputs();
    s = model_stall();
    @(posedge CLK);
    if (pipe_en) begin
      if (flush || s) ins = '0;
      else ins = '{regwr: id_regwr && (id_wsel != 5'd0), wsel: id_wsel,
                   memread: id_memread, lui: id_lui};
      slots.push_front(ins);
      void'(slots.pop_back());
      if (s && model_cnt < 65535) model_cnt++;
    end
    @(negedge CLK);
  endtask

  task automatic nop();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_stall"}, int'(stall), 0);
    check({tag, "_mem_regwr"}, int'(mem_regwr), 0);
    check({tag, "_mem_wsel"}, int'(mem_wsel), 0);
    check({tag, "_mem_lui"}, int'(mem_lui), 0);
    check({tag, "_wb_regwr"}, int'(wb_regwr), 0);
    check({tag, "_wb_wsel"}, int'(wb_wsel), 0);
    check({tag, "_count"}, int'(stall_count), 0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_reset();
    nRST = 1'b0;
    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom), 5'($urandom), 5'($urandom));
      @(negedge CLK);
      check_zero("rst");
    end
    nop();
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // ALU producer, consumer of r3 does not stall
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3); step();
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 5'd4, 5'd10);
    #1 check("alu_stall", int'(stall), 0);
    step();
    check("alu_mem_regwr", int'(mem_regwr), 1);
    check("alu_mem_wsel", int'(mem_wsel), 3);
    nop(); step();
    check("alu_wb_regwr", int'(wb_regwr), 1);
    check("alu_wb_wsel", int'(wb_wsel), 3);
    nop(); step(); step();

    // Load-use: one stall cycle, then load covered from MEM
    apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 5'd2, 5'd5); step();
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 5'd0, 5'd6);
    #1 check("lu_stall", int'(stall), 1);
    step();
    #1 check("lu_stall_clear", int'(stall), 0);
    check("lu_mem_wsel", int'(mem_wsel), 5);
    step();
    nop(); step(); step(); step();

    // Hold: stall persists while pipe_en low
    apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd8); step();
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd8, 5'd1, 5'd2);
    for (int i = 0; i < 3; i++) begin
      #1 check("hold_stall", int'(stall), 1);
      step();
    end
    pipe_en = 1'b1; step();
    #1 check("hold_clear", int'(stall), 0);
    step();
    nop(); step(); step(); step();

    // $0 load never stalls or writes; lui flag travels to MEM only
    apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0); step();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1 check("z_stall", int'(stall), 0);
    step();
    check("z_mem_regwr", int'(mem_regwr), 0);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd7); step();
    nop(); step();
    check("lui_mem_lui", int'(mem_lui), 1);
    check("lui_mem_wsel", int'(mem_wsel), 7);
    step();
    check("lui_wb_wsel", int'(wb_wsel), 7);
    check("lui_mem_lui_gone", int'(mem_lui), 0);
    step(); step();

    // Flushed load is squashed
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd9); step();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 5'd9, 5'd0);
    #1 check("fl_stall", int'(stall), 0);
    step();
    check("fl_mem_regwr", int'(mem_regwr), 0);

    // Random traffic with occasional mid-operation reset
    for (int i = 0; i < 600; i++) begin
      apply(($urandom_range(3, 0) != 0), ($urandom_range(9, 0) == 0), 1'($urandom),
            ($urandom_range(2, 0) == 0), ($urandom_range(5, 0) == 0),
            5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)));
      if (i % 150 == 149) begin
        #2 nRST = 1'b0;
        #1 check_zero("mid_rst");
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Producer-side companion to the pipeline's forwarding logic. Keeps a shadow copy of the destination-register information for the instructions in EX, MEM and WB, advancing it in lockstep with the pipeline latches. Drives the MEM/WB write-select information that forwarding consumes, and raises the load-use stall that forwarding cannot resolve. Sits beside the ID/EX latch. Inputs come from decode; outputs go to the forwarding unit and to the pipeline enable logic.

## Interface
- `REGW`, default 5: register-index width.
- `CLK` input, 1: pipeline clock, rising edge.
- `nRST` input, 1: asynchronous, active-low reset.
- `pipe_en` input, 1: all pipeline latches advance this cycle.
- `flush` input, 1: squash the instruction entering EX (taken branch or jump).
- `id_rs` input, REGW: rs field of the ID instruction.
- `id_rt` input, REGW: rt field of the ID instruction.
- `id_regwr` input, 1: the ID instruction writes the register file.
- `id_wsel` input, REGW: destination register of the ID instruction.
- `id_memread` input, 1: the ID instruction is a load.
- `id_lui` input, 1: the ID instruction is lui.
- `stall` output, 1: load-use hazard. Freezes PC and IF/ID, and forces a bubble into EX.
- `mem_regwr` output, 1: the MEM-slot instruction writes a register.
- `mem_wsel` output, REGW: destination register of the MEM slot.
- `mem_lui` output, 1: the MEM-slot instruction is lui.
- `wb_regwr` output, 1: the WB-slot instruction writes a register.
- `wb_wsel` output, REGW: destination register of the WB slot.
- `stall_count` output, 16: saturating count of stall cycles. Present only with `HAZARD_PERF_EN`.

## Operation
- Three slots: EX, MEM and WB. Each slot holds {regwr, wsel, memread, lui}.
- Insert value for the EX slot:
  - Normally the ID fields.
  - regwr is forced to 0 when id_wsel == 0, so the outputs never show a write to $0.
  - The insert is a bubble (all fields 0) when `flush` or `stall` is high.
  - flush and stall together still give one bubble, and flush needs no extra handling.
- Slot update on a rising CLK edge:
  - With pipe_en=1: WB←MEM, MEM←EX, EX←insert.
  - With pipe_en=0: all slots hold, and flush/stall have no state effect that cycle.
- Stall is combinational:
  - stall = EX.regwr & EX.memread & ((EX.wsel==id_rs) | (EX.wsel==id_rt)).
  - EX.wsel≠0 is already guaranteed by the insert rule.
  - rt is compared even when the ID instruction does not read it. This is conservative and intended.
  - stall does not depend on pipe_en. Pipeline control combines the two.
- After one stall bubble the load sits in MEM, where forwarding covers it. stall therefore lasts exactly one advancing cycle per load-use pair.
- The outputs are the MEM and WB slot fields read directly from flops. No combinational path runs from the ID inputs to them.
- MEM-slot memread is not exported, because the stall guarantees that no consumer needs load data from MEM.

## Timing
- Reset (nRST low, asynchronous): every slot is cleared to 0. stall, mem_*, wb_* and stall_count all read 0.
- Reset can be asserted mid-operation. In-flight entries are dropped and no stall is pending after release.
- Latency from an instruction's ID cycle to its outputs, counting advancing edges:
  - mem_* valid after 2 edges.
  - wb_* valid after 3 edges.
  - The entry leaves after 4 edges.
- stall responds in the same cycle as the id_* change (combinational).
- pipe_en low at any point stretches all latencies by the number of held cycles.

## Configuration
- `HAZARD_PERF_EN` defined:
  - The `stall_count` port and a 16-bit counter are present.
  - The counter increments on each edge where stall & pipe_en, and saturates at 0xFFFF.
  - It resets to 0 on nRST.
- `HAZARD_PERF_EN` undefined: no port, no counter. Stall and forwarding behaviour are identical in both builds.

## Test plan
- Reset: hold nRST=0 with random inputs -> all outputs 0. After release with no writes issued, all outputs stay 0.
- ALU producer: issue id_regwr=1, id_wsel=3, then a consumer with rs=3 -> stall=0. On edge 2, mem_regwr=1, mem_wsel=3. On edge 3, wb_regwr=1, wb_wsel=3.
- Load-use: issue lw with wsel=5, then id_rs=5 with pipe_en=1 -> stall=1 for exactly one cycle and EX gets a bubble. On the next cycle stall=0 and mem_wsel=5. stall_count=1.
- Hold: put the load in EX and a dependent instruction in ID, with pipe_en=0 for 3 cycles -> stall=1 for all 3 cycles, slots unchanged, stall_count unchanged. One pipe_en=1 edge then clears the hazard.
- $0 and lui: issue lw with wsel=0, then rs=0 -> stall=0 and mem_regwr stays 0. Issue lui with wsel=7 -> mem_lui=1 on edge 2, and wb_wsel=7 with no lui flag on edge 3.
- Flush: a load with wsel=9 in ID and flush=1 on an advancing edge -> EX gets a bubble. A following consumer with rs=9 gives stall=0, and mem_regwr=0 one edge later.
